// File: rtl/pipelined_alu.sv
// pipelined_alu: handshaked execute-stage ALU with registered result/zero.
//
// Single-cycle ops (AND/OR/ADD/XOR/SLL/SRL/SUB/SLTU/SLT/SRA, illegal) produce
// out_valid one cycle after accept. MUL/MULHU (and DIVU/REMU when enabled)
// run a fixed WIDTH-iteration shift-add / restoring-divide loop.
//
// Optional feature macro: PIPELINED_ALU_DIV_EN
//   defined   -> DIVU/REMU implemented (RISC-V divide-by-zero semantics)
//   undefined -> divider removed, 1100/1101 decode as illegal (result 0)
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid/in_ready   input handshake for a, b, alu_control
//   out_valid/out_ready output handshake for result, zero
//   result, zero        registered result and (result == 0)
//   busy                high while a multi-cycle op is iterating
module pipelined_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SLL   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLTU  = 4'b0111;
  localparam logic [3:0] OP_SLT   = 4'b1000;
  localparam logic [3:0] OP_SRA   = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_MULHU = 4'b1011;
`ifdef PIPELINED_ALU_DIV_EN
  localparam logic [3:0] OP_DIVU  = 4'b1100;
  localparam logic [3:0] OP_REMU  = 4'b1101;
`endif

  localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t             r_state;
  logic [SHW:0]       r_count;
  logic               r_opHi;
  logic [WIDTH-1:0]   r_opnd;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_outValid;
  logic [WIDTH-1:0]   r_result;
  logic               r_zero;

  logic [SHW-1:0]     w_shamt;
  logic [WIDTH-1:0]   w_aluResult;
  logic               w_isMulti;
  logic               w_accept;
  logic [WIDTH:0]     w_mulSum;
  logic [2*WIDTH-1:0] w_mulNext;
  logic [2*WIDTH-1:0] w_iterNext;
  logic [WIDTH-1:0]   w_finalResult;

  assign w_shamt   = b[SHW-1:0];
  assign in_ready  = (r_state == ST_IDLE) && (!r_outValid || out_ready);
  assign w_accept  = in_valid && in_ready;
  assign busy      = (r_state == ST_BUSY);
  assign out_valid = r_outValid;
  assign result    = r_result;
  assign zero      = r_zero;

  // Single-cycle datapath; multi-cycle and illegal encodings yield 0 here.
  always_comb begin
    w_aluResult = '0;
    case (alu_control)
      OP_AND:  w_aluResult = a & b;
      OP_OR:   w_aluResult = a | b;
      OP_ADD:  w_aluResult = a + b;
      OP_XOR:  w_aluResult = a ^ b;
      OP_SLL:  w_aluResult = a << w_shamt;
      OP_SRL:  w_aluResult = a >> w_shamt;
      OP_SUB:  w_aluResult = a - b;
      OP_SLTU: w_aluResult = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLT:  w_aluResult = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SRA:  w_aluResult = $unsigned($signed(a) >>> w_shamt);
      default: w_aluResult = '0;
    endcase
  end

  // Which encodings take the iterative path.
  always_comb begin
    w_isMulti = 1'b0;
    case (alu_control)
      OP_MUL, OP_MULHU: w_isMulti = 1'b1;
`ifdef PIPELINED_ALU_DIV_EN
      OP_DIVU, OP_REMU: w_isMulti = 1'b1;
`endif
      default:          w_isMulti = 1'b0;
    endcase
  end

  // Shift-add multiply: upper half accumulates the multiplicand when the
  // current multiplier bit (acc[0]) is set, then the whole product shifts right.
  assign w_mulSum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mulNext = {w_mulSum, r_acc[WIDTH-1:1]};

`ifdef PIPELINED_ALU_DIV_EN
  logic               r_opDiv;
  logic [WIDTH:0]     w_remShift;
  logic               w_divGe;
  logic [WIDTH-1:0]   w_divDiff;
  logic [2*WIDTH-1:0] w_divNext;

  // Restoring divide: acc = {remainder, dividend/quotient}. With a zero
  // divisor every step "succeeds", giving all-ones quotient and remainder = a.
  assign w_remShift = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_divGe    = (w_remShift >= {1'b0, r_opnd});
  assign w_divDiff  = w_remShift[WIDTH-1:0] - r_opnd;
  assign w_divNext  = {(w_divGe ? w_divDiff : w_remShift[WIDTH-1:0]),
                       r_acc[WIDTH-2:0], w_divGe};
  assign w_iterNext = r_opDiv ? w_divNext : w_mulNext;
`else
  assign w_iterNext = w_mulNext;
`endif

  // MULHU (1011) and REMU (1101) both take the upper half; MUL/DIVU the lower.
  assign w_finalResult = r_opHi ? w_iterNext[2*WIDTH-1:WIDTH] : w_iterNext[WIDTH-1:0];

  // Control FSM plus result/handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_opHi     <= 1'b0;
      r_opnd     <= '0;
      r_acc      <= '0;
      r_outValid <= 1'b0;
      r_result   <= '0;
      r_zero     <= 1'b1;
`ifdef PIPELINED_ALU_DIV_EN
      r_opDiv    <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_isMulti) begin
              r_state    <= ST_BUSY;
              r_count    <= CNT_INIT;
              r_opHi     <= alu_control[0];
              r_outValid <= 1'b0;
`ifdef PIPELINED_ALU_DIV_EN
              r_opDiv    <= alu_control[2];
              if (alu_control[2]) begin
                r_acc  <= {{WIDTH{1'b0}}, a};
                r_opnd <= b;
              end else begin
                r_acc  <= {{WIDTH{1'b0}}, b};
                r_opnd <= a;
              end
`else
              r_acc      <= {{WIDTH{1'b0}}, b};
              r_opnd     <= a;
`endif
            end else begin
              r_result   <= w_aluResult;
              r_zero     <= (w_aluResult == '0);
              r_outValid <= 1'b1;
            end
          end else if (out_ready) begin
            r_outValid <= 1'b0;
          end
        end
        ST_BUSY: begin
          r_acc   <= w_iterNext;
          r_count <= r_count - CNT_ONE;
          if (r_count == CNT_ONE) begin
            r_result   <= w_finalResult;
            r_zero     <= (w_finalResult == '0);
            r_outValid <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipelined_alu.sv
// Testbench for pipelined_alu (WIDTH=32). A driver pushes hand-computed
// expectations into a queue on accept; a monitor pops on each output
// handshake and also checks latency, busy length and in_ready during busy.
module tb_pipelined_alu;

  localparam int WIDTH = 32;
  localparam int LAT1  = 1;
  localparam int LATM  = WIDTH + 1;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SLL   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLTU  = 4'b0111;
  localparam logic [3:0] OP_SLT   = 4'b1000;
  localparam logic [3:0] OP_SRA   = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_MULHU = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1100;
  localparam logic [3:0] OP_REMU  = 4'b1101;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alu_control;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             zero;
    int               cyc;
    string            name;
  } exp_t;

  exp_t expQ[$];
  int   nCompared   = 0;
  int   nMismatched = 0;
  int   cyc         = 0;
  bit   seenValid   = 0;
  bit   abortFlag   = 0;
  bit   inReadyBad  = 0;
  int   busyRun     = 0;

  pipelined_alu #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .alu_control (alu_control),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] act,
                             input logic [WIDTH-1:0] req);
    nCompared++;
    if (act !== req) begin
      nMismatched++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Called at a falling edge; presents one op, waits (bounded) for in_ready,
  // queues the expectation and returns at the falling edge after the accept.
  task automatic applyStimulus(input string name, input logic [3:0] op,
                               input logic [WIDTH-1:0] opA, input logic [WIDTH-1:0] opB,
                               input logic [WIDTH-1:0] expRes, input int lat);
    exp_t e;
    bit   accepted;
    accepted    = 0;
    in_valid    = 1'b1;
    alu_control = op;
    a           = opA;
    b           = opB;
    for (int i = 0; i < 100 && !accepted; i++) begin
      #1;
      if (in_ready) begin
        e.res  = expRes;
        e.zero = (expRes == '0);
        e.cyc  = cyc + lat;
        e.name = name;
        expQ.push_back(e);
        accepted = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (!accepted) checkOutput({name, " accept timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drainWait();
    for (int i = 0; i < 200 && expQ.size() != 0; i++) @(negedge clk);
    if (expQ.size() != 0) checkOutput("drain timeout", 32'(expQ.size()), 32'd0);
  endtask

  // Monitor: scoreboard pop on handshake, latency on first sight, busy checks.
  always begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (busy) begin
        busyRun++;
        if (in_ready) inReadyBad = 1;
      end else if (busyRun > 0) begin
        if (!abortFlag) begin
          checkOutput("busy cycles", 32'(busyRun), 32'(WIDTH));
          checkOutput("in_ready during busy", 32'(inReadyBad), 32'd0);
        end
        busyRun    = 0;
        inReadyBad = 0;
        abortFlag  = 0;
      end
      if (out_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected out_valid", 32'd1, 32'd0);
        end else begin
          if (!seenValid) begin
            checkOutput({expQ[0].name, " latency"}, 32'(cyc), 32'(expQ[0].cyc));
            seenValid = 1;
          end
          if (out_ready) begin
            checkOutput({expQ[0].name, " result"}, result, expQ[0].res);
            checkOutput({expQ[0].name, " zero"}, 32'(zero), 32'(expQ[0].zero));
            void'(expQ.pop_front());
            seenValid = 0;
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    a           = '0;
    b           = '0;
    alu_control = '0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset result", result, 32'd0);
    checkOutput("reset zero", 32'(zero), 32'd1);
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] single-cycle ops");
    applyStimulus("ADD wrap", OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, LAT1);
    applyStimulus("SUB", OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, LAT1);
    applyStimulus("SLTU", OP_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, LAT1);
    applyStimulus("SLT", OP_SLT, 32'hFFFF_FFFF, 32'h1, 32'h1, LAT1);
    applyStimulus("AND", OP_AND, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, LAT1);
    applyStimulus("OR", OP_OR, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, LAT1);
    applyStimulus("XOR", OP_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, LAT1);
    applyStimulus("SRL", OP_SRL, 32'h8000_0000, 32'h4, 32'h0800_0000, LAT1);
    applyStimulus("SRA", OP_SRA, 32'h8000_0000, 32'h24, 32'hF800_0000, LAT1);
    applyStimulus("SLL", OP_SLL, 32'h1, 32'd31, 32'h8000_0000, LAT1);
    applyStimulus("illegal 1110", 4'b1110, 32'h5, 32'h3, 32'h0, LAT1);
    applyStimulus("illegal 1111", 4'b1111, 32'hFFFF_FFFF, 32'h1, 32'h0, LAT1);
    drainWait();

    $display("[TB] multi-cycle ops");
    applyStimulus("MUL 2^32", OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0, LATM);
    applyStimulus("MULHU 2^32", OP_MULHU, 32'h0001_0000, 32'h0001_0000, 32'h1, LATM);
    applyStimulus("MUL 7x6", OP_MUL, 32'd7, 32'd6, 32'd42, LATM);
    applyStimulus("MULHU max", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LATM);
    applyStimulus("MUL max", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, LATM);
`ifdef PIPELINED_ALU_DIV_EN
    applyStimulus("DIVU 100/7", OP_DIVU, 32'd100, 32'd7, 32'd14, LATM);
    applyStimulus("REMU 100/7", OP_REMU, 32'd100, 32'd7, 32'd2, LATM);
    applyStimulus("DIVU x/0", OP_DIVU, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, LATM);
    applyStimulus("REMU x/0", OP_REMU, 32'd123, 32'h0, 32'd123, LATM);
`else
    applyStimulus("DIVU disabled", OP_DIVU, 32'd100, 32'd7, 32'h0, LAT1);
    applyStimulus("REMU disabled", OP_REMU, 32'd100, 32'd7, 32'h0, LAT1);
`endif
    drainWait();

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus("ADD held", OP_ADD, 32'd10, 32'd20, 32'd30, LAT1);
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("held out_valid", 32'(out_valid), 32'd1);
      checkOutput("held result", result, 32'd30);
      checkOutput("held in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    applyStimulus("ADD 2+3", OP_ADD, 32'd2, 32'd3, 32'd5, LAT1);
    drainWait();

    $display("[TB] reset during multi-cycle op");
`ifdef PIPELINED_ALU_DIV_EN
    applyStimulus("DIVU aborted", OP_DIVU, 32'd100, 32'd7, 32'd14, LATM);
`else
    applyStimulus("MUL aborted", OP_MUL, 32'd100, 32'd7, 32'd700, LATM);
`endif
    repeat (9) @(negedge clk);
    #3;
    rst_n     = 1'b0;
    abortFlag = 1;
    expQ.delete();
    seenValid = 0;
    #1;
    checkOutput("abort out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort result", result, 32'd0);
    checkOutput("abort zero", 32'(zero), 32'd1);
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    checkOutput("post-abort out_valid", 32'(out_valid), 32'd0);
    checkOutput("post-abort busy", 32'(busy), 32'd0);

    applyStimulus("ADD after abort", OP_ADD, 32'd1, 32'd1, 32'd2, LAT1);
    drainWait();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
